// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receive and transmit sides:
//     - rx_state_t          : receive FSM state encoding
//     - calc_clks_per_bit() : system clocks per line bit (integer division)
//     - calc_half_bit()     : clocks from a start edge to mid-bit
// -----------------------------------------------------------------------------
package uart_pkg;

    // Receive FSM states. Explicit encoding keeps the values stable in
    // waveforms and across both halves of the UART.
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Clocks per line bit. Truncating division: the residual baud error is
    // absorbed by mid-bit sampling.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Distance from the detected start edge to the centre of the start bit.
    function automatic int calc_half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//   Two-flop synchronizer for a single asynchronous input.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high; both flops load RESET_VALUE
//     d      : asynchronous input
//     q      : synchronized output, two clocks behind d
//   Parameter RESET_VALUE sets the flop value during reset (1 for an idle-high
//   UART line, so reset release never looks like a start edge).
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q sample together on the
    // edge, forming two real flops; blocking here would collapse them into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : uart_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver: 1 start bit, DATA_BITS data bits (LSB first), STOP_BITS
//   stop bits, no parity. The line is synchronized, the start bit is
//   re-checked at mid-bit to reject glitches, and every following bit is
//   sampled at CLKS_PER_BIT spacing from that mid-start point.
//
//   Ports:
//     clk        : system clock, rising edge
//     reset      : synchronous, active-high
//     rx         : asynchronous serial line, idle high
//     rx_data    : payload of the last accepted frame (stable while rx_valid)
//     rx_valid   : rx_data holds a frame not yet consumed
//     rx_ready   : consumer takes rx_data in a cycle where rx_valid is high
//     busy       : receive FSM is not idle
//     frame_err  : one-cycle pulse when a stop bit is sampled low
//     overrun    : one-cycle pulse when a good frame is dropped because the
//                  output register is still occupied
//
//   The receive FSM never waits on rx_ready; the handshake only governs the
//   output register.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);
    localparam int CLK_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W        = $clog2(DATA_BITS + STOP_BITS) + 1;

    // Terminal counts, pre-sized to the counters they are compared against.
    localparam logic [CLK_W-1:0] LAST_CLK  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    logic                 rx_sync;
    rx_state_t            state;
    logic [CLK_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_ok;     // AND of stop samples taken so far

    // Line synchronizer; resets high so reset release is not a start edge.
    uart_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_sync)
    );

    // Pure decode of the state register, so it tracks the FSM exactly.
    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the payload registers are reset too: rx_data is a visible
            // output and must read 0 after reset, not leftover frame bits.
            state     <= RX_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            stop_ok   <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Status pulses last a single cycle unless re-asserted below.
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake. A frame loaded further down in this same
            // cycle overrides this clear (last assignment wins).
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state   <= RX_START;
                        clk_cnt <= '0;
                    end
                end

                // Re-check the line at mid start bit; a high sample means the
                // falling edge was a glitch and is dropped without any pulse.
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // One sample per bit period; shifting in from the top leaves
                // the first received bit in the LSB.
                RX_DATA: begin
                    if (clk_cnt == LAST_CLK) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            stop_ok <= 1'b1;
                            state   <= RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (clk_cnt == LAST_CLK) begin
                        clk_cnt <= '0;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            if (stop_ok && rx_sync) begin
                                state <= RX_IDLE;
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift_reg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    // Occupied output: keep the old frame.
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= RX_WAIT_IDLE;
                            end
                        end else begin
                            stop_ok <= stop_ok & rx_sync;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // After a framing error the line may be in break or stuck
                // low; only a return to high re-arms start detection.
                RX_WAIT_IDLE: begin
                    if (rx_sync) begin
                        state <= RX_IDLE;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx at CLK_FREQ=1600, BAUD_RATE=100
//   (16 clocks per bit, 8 clocks to mid-bit). Directed scenarios followed by
//   random frames compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ  = 1600;
    localparam int BAUD_RATE = 100;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = BIT_CLKS / 2;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Event totals maintained by the monitor; the stimulus takes snapshots.
    int         fe_total     = 0;
    int         ov_total     = 0;
    int         valid_cycles = 0;
    logic [7:0] got_q[$];

    int fe0, ov0, v0, g0;
    logic [7:0] exp_q[$];
    int exp_fe;
    bit ok;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_total++;
            if (overrun) ov_total++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snapshot();
        fe0 = fe_total;
        ov0 = ov_total;
        v0  = valid_cycles;
        g0  = got_q.size();
    endtask

    // Drive one frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_clks);
        rx = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BIT_CLKS);
        end
        rx = stop_bit;
        tick(stop_clks);
    endtask

    task automatic wait_busy_low(input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         bad;

        // Reset state
        reset = 1'b1;
        tick(3);
        check("reset_rx_data",   32'(rx_data),   32'h0);
        check("reset_rx_valid",  32'(rx_valid),  32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun",   32'(overrun),   32'h0);
        reset = 1'b0;
        tick(5);

        // Single frame 0xA5 with rx_ready held high
        rx_ready = 1'b1;
        snapshot();
        send_frame(8'hA5, 1'b1, BIT_CLKS);
        tick(20);
        check("a5_count",        got_q.size() - g0, 1);
        check("a5_data",         32'(got_q[g0]),    32'hA5);
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_busy",         32'(busy),         32'h0);
        check("a5_frame_err",    fe_total - fe0,    0);
        check("a5_overrun",      ov_total - ov0,    0);

        // Short low glitch: rejected at mid start bit
        snapshot();
        rx = 1'b0;
        tick(4);
        check("glitch_busy_seen", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_busy_low(HALF + 2, ok);
        check("glitch_busy_drop", 32'(ok), 32'h1);
        tick(20);
        check("glitch_no_valid", valid_cycles - v0, 0);
        check("glitch_no_ferr",  fe_total - fe0,    0);

        // Bad stop bit, line held low 40 clocks
        snapshot();
        send_frame(8'h3C, 1'b0, 40);
        check("break_busy",      32'(busy),         32'h1);
        check("break_ferr",      fe_total - fe0,    1);
        check("break_no_valid",  valid_cycles - v0, 0);
        rx = 1'b1;
        wait_busy_low(6, ok);
        check("break_release",   32'(ok),           32'h1);
        tick(20);
        check("break_ferr_once", fe_total - fe0,    1);

        // Overrun: two frames with rx_ready low
        rx_ready = 1'b0;
        snapshot();
        send_frame(8'h11, 1'b1, BIT_CLKS);
        tick(20);
        send_frame(8'h22, 1'b1, BIT_CLKS);
        tick(20);
        check("ovr_valid",   32'(rx_valid),  32'h1);
        check("ovr_data",    32'(rx_data),   32'h11);
        check("ovr_pulse",   ov_total - ov0, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("ovr_consumed", 32'(got_q[got_q.size() - 1]), 32'h11);
        check("ovr_cleared",  32'(rx_valid), 32'h0);

        // Consume exactly on the load cycle of the second frame. The final
        // stop sample lands on the 155th rising edge after the start bit is
        // driven: 2 synchronizer stages, 1 to leave idle, 8 to mid-start,
        // then 9 bit periods of 16.
        snapshot();
        send_frame(8'h11, 1'b1, BIT_CLKS);
        tick(20);
        fork
            send_frame(8'h22, 1'b1, BIT_CLKS);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        tick(20);
        check("same_cycle_data",    32'(rx_data),       32'h22);
        check("same_cycle_valid",   32'(rx_valid),      32'h1);
        check("same_cycle_overrun", ov_total - ov0,     0);
        check("same_cycle_took_11", 32'(got_q[g0]),     32'h11);
        rx_ready = 1'b1;
        tick(1);
        check("same_cycle_took_22", 32'(got_q[got_q.size() - 1]), 32'h22);

        // Reset in the middle of data bit 4 of 0xFF, then a clean 0x5A
        rx = 1'b0;
        tick(BIT_CLKS);
        rx = 1'b1;
        tick(4 * BIT_CLKS + HALF);
        check("midreset_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        tick(2);
        check("midreset_rx_data",   32'(rx_data),   32'h0);
        check("midreset_rx_valid",  32'(rx_valid),  32'h0);
        check("midreset_busy",      32'(busy),      32'h0);
        check("midreset_frame_err", 32'(frame_err), 32'h0);
        check("midreset_overrun",   32'(overrun),   32'h0);
        reset = 1'b0;
        tick(5);
        check("midreset_idle", 32'(busy), 32'h0);
        snapshot();
        send_frame(8'h5A, 1'b1, BIT_CLKS);
        tick(20);
        check("post_reset_data", 32'(got_q[g0]),  32'h5A);
        check("post_reset_ferr", fe_total - fe0, 0);

        // Random frames, about one in five with a corrupted stop bit.
        // Model: good frames deliver their byte in order, bad ones raise
        // exactly one frame error and deliver nothing.
        rx_ready = 1'b1;
        snapshot();
        exp_q.delete();
        exp_fe = 0;
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, !bad, BIT_CLKS);
            rx = 1'b1;
            if (bad) exp_fe++;
            else     exp_q.push_back(d);
            tick($urandom_range(4, 30));
        end
        tick(20);
        check("rand_count",   got_q.size() - g0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand_data_%0d", i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
        end
        check("rand_ferr",    fe_total - fe0, exp_fe);
        check("rand_overrun", ov_total - ov0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port rx_data  output  DATA_BITS  last accepted frame payload.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unconsumed frame.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a good frame is dropped.

Function
REQ-014 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division) and HALF_BIT = CLKS_PER_BIT/2.
REQ-015 SHALL pass rx through a 2-flop synchronizer; FSM sees rx 2 cycles late; all sampling uses the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE; bit counter sized $clog2(DATA_BITS+STOP_BITS)+1, clock counter sized $clog2(CLKS_PER_BIT)+1.
REQ-017 IDLE: synced rx == 0 -> START, clock counter cleared.
REQ-018 START: after HALF_BIT clocks, sample; 0 -> DATA with counters cleared; 1 -> IDLE silently (glitch rejection).
REQ-019 DATA: sample every CLKS_PER_BIT clocks from mid-start; shift in LSB first; after DATA_BITS samples -> STOP.
REQ-020 STOP: sample each stop bit at CLKS_PER_BIT spacing; after last stop sample go to IDLE if all stop samples 1, else pulse frame_err, discard payload, go to WAIT_IDLE.
REQ-021 WAIT_IDLE: remain until synced rx == 1, then IDLE (no restart on break/stuck-low line).
REQ-022 Good frame: cycle after final stop sample, if rx_valid == 0 or rx_ready == 1, SHALL load rx_data and set rx_valid.
REQ-023 Good frame while rx_valid == 1 and rx_ready == 0: SHALL keep old rx_data, keep rx_valid, pulse overrun.
REQ-024 rx_valid SHALL clear in cycle after rx_valid && rx_ready, unless REQ-022 loads a new frame same cycle (rx_valid stays 1, no overrun).
REQ-025 rx_data SHALL stay stable while rx_valid is high; rx_ready while rx_valid is low is ignored.
REQ-026 Receive FSM SHALL never stall on rx_ready; handshake affects only output register.

Reset
REQ-027 On reset: state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid 0, busy 0, frame_err 0, overrun 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no pulse; next falling edge after reset release starts a fresh frame.

Structure
REQ-029 Shared package uart_pkg SHALL hold the rx state encoding and the CLKS_PER_BIT/HALF_BIT derivation function, reused by uart_tx side.
REQ-030 Synchronizer SHALL be a sub-module uart_sync (2 flops, reset value parameterized, here 1).

Verification (CLK_FREQ=1600, BAUD_RATE=100 -> CLKS_PER_BIT 16, HALF_BIT 8)
REQ-031 Frame 0xA5, rx_ready held 1 -> rx_data=0xA5, rx_valid high exactly 1 cycle, busy low after stop, no pulses.
REQ-032 rx low 4 clocks then high -> no rx_valid, busy returns 0 within HALF_BIT+2 clocks, no frame_err.
REQ-033 Frame 0x3C with stop bit 0, line held low 40 clocks -> one frame_err pulse, no rx_valid, busy high until line high.
REQ-034 Frames 0x11 then 0x22, rx_ready 0 -> rx_data=0x11 held, one overrun pulse at 0x22 completion.
REQ-035 Repeat REQ-034 with rx_ready 1 exactly on 0x22 load cycle -> rx_data=0x22, rx_valid stays 1, no overrun.
REQ-036 Reset during data bit 4 of 0xFF, then frame 0x5A -> all outputs 0 after reset, then rx_data=0x5A, no frame_err.
